// File: rtl/epp_cmd_dispatcher.sv
// EPP command front end: assembles 3-byte frames from the host strobe, queues them, and
// dispatches each in order to the DAC or digital-pot shifter with a start/busy handshake.
module epp_cmd_dispatcher #(
    parameter int TIMEOUT    = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        dataStb,
    input  logic [7:0]  busBramIn,
    output logic [7:0]  busBramOut,
    input  logic        dacBusy,
    output logic        dacStart,
    output logic [15:0] dacWord,
    input  logic        potBusy,
    output logic        potStart,
    output logic [1:0]  potSel,
    output logic [7:0]  potWord
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [1:0] {S_CMD, S_HI, S_LO} asm_state_t;
    typedef enum logic [1:0] {D_IDLE, D_START, D_ACK, D_WAIT} disp_state_t;

    // ---------------- input synchroniser ----------------
    // Strobe flops reset high so an idle (high) strobe never looks like a rising edge.
    logic [2:0] stb_q;
    logic [7:0] din1_q, din2_q;
    logic       byte_acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stb_q  <= 3'b111;
            din1_q <= '0;
            din2_q <= '0;
        end else begin
            stb_q  <= {stb_q[1:0], dataStb};
            din1_q <= busBramIn;
            din2_q <= din1_q;
        end
    end

    assign byte_acc = stb_q[1] & ~stb_q[2];

    // ---------------- frame assembler ----------------
    asm_state_t    asm_q, asm_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [7:0]    hi_q, hi_d, lo_q, lo_d;
    logic          push_q, push_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          ovf_q, ovf_d, tmo_q, tmo_d, cerr_q, cerr_d;
    logic          timeout;
    logic          push_ok;

    always_comb begin
        asm_d     = asm_q;
        tgt_d     = tgt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        push_d    = 1'b0;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        cerr_d    = cerr_q;
        timeout   = (asm_q != S_CMD) && !byte_acc && (tmo_cnt_q == TW'(TIMEOUT));
        tmo_cnt_d = (byte_acc || asm_q == S_CMD || timeout) ? '0 : tmo_cnt_q + TW'(1);

        case (asm_q)
            S_CMD: begin
                if (byte_acc) begin
                    if (din2_q[7:2] == 6'd0) begin
                        tgt_d = din2_q[1:0];
                        asm_d = S_HI;
                    end else if (din2_q == 8'h80) begin
                        ovf_d  = 1'b0;
                        tmo_d  = 1'b0;
                        cerr_d = 1'b0;
                    end else begin
                        cerr_d = 1'b1;
                    end
                end
            end
            S_HI: begin
                if (byte_acc) begin
                    hi_d  = din2_q;
                    asm_d = S_LO;
                end else if (timeout) begin
                    tmo_d = 1'b1;
                    asm_d = S_CMD;
                end
            end
            S_LO: begin
                if (byte_acc) begin
                    lo_d   = din2_q;
                    push_d = 1'b1;
                    asm_d  = S_CMD;
                end else if (timeout) begin
                    tmo_d = 1'b1;
                    asm_d = S_CMD;
                end
            end
            default: asm_d = S_CMD;
        endcase

        if (push_q && !push_ok) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            asm_q     <= S_CMD;
            tgt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            push_q    <= 1'b0;
            tmo_cnt_q <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            cerr_q    <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            tgt_q     <= tgt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            push_q    <= push_d;
            tmo_cnt_q <= tmo_cnt_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            cerr_q    <= cerr_d;
        end
    end

    // ---------------- frame queue ----------------
    logic [17:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [17:0]   head;
    logic [1:0]    head_tgt;
    logic          fifo_empty, fifo_full, head_busy, pop;
    disp_state_t   disp_q, disp_d;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign head       = mem_q[rd_ptr_q];
    assign head_tgt   = head[17:16];
    assign head_busy  = (head_tgt == 2'd0) ? dacBusy : potBusy;
    assign pop        = (disp_q == D_IDLE) && !fifo_empty && !head_busy;
    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    assign push_ok    = push_q && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {tgt_q, hi_q, lo_q};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // ---------------- dispatcher ----------------
    logic [1:0]  cur_tgt_q, cur_tgt_d;
    logic        dac_start_q, dac_start_d, pot_start_q, pot_start_d;
    logic [15:0] dac_word_q, dac_word_d;
    logic [1:0]  pot_sel_q, pot_sel_d;
    logic [7:0]  pot_word_q, pot_word_d;
    logic        cur_busy;

    assign cur_busy = (cur_tgt_q == 2'd0) ? dacBusy : potBusy;

    always_comb begin
        disp_d      = disp_q;
        cur_tgt_d   = cur_tgt_q;
        dac_start_d = 1'b0;
        pot_start_d = 1'b0;
        dac_word_d  = dac_word_q;
        pot_sel_d   = pot_sel_q;
        pot_word_d  = pot_word_q;

        case (disp_q)
            D_IDLE: begin
                if (pop) begin
                    cur_tgt_d = head_tgt;
                    disp_d    = D_START;
                    if (head_tgt == 2'd0) begin
                        dac_word_d  = head[15:0];
                        dac_start_d = 1'b1;
                    end else begin
                        pot_sel_d   = head_tgt - 2'd1;
                        pot_word_d  = head[7:0];
                        pot_start_d = 1'b1;
                    end
                end
            end
            D_START: disp_d = D_ACK;
            D_ACK:   disp_d = D_WAIT;
            D_WAIT:  if (!cur_busy) disp_d = D_IDLE;
            default: disp_d = D_IDLE;
        endcase
    end

    logic [2:0] cnt_sat;
    logic [7:0] status_d, status_q;

    always_comb begin
        cnt_sat  = (int'(cnt_q) > 7) ? 3'd7 : 3'(cnt_q);
        status_d = {ovf_q, tmo_q, cerr_q, cnt_sat, disp_q != D_IDLE, asm_q != S_CMD};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_q      <= D_IDLE;
            cur_tgt_q   <= '0;
            dac_start_q <= 1'b0;
            pot_start_q <= 1'b0;
            dac_word_q  <= '0;
            pot_sel_q   <= '0;
            pot_word_q  <= '0;
            status_q    <= '0;
        end else begin
            disp_q      <= disp_d;
            cur_tgt_q   <= cur_tgt_d;
            dac_start_q <= dac_start_d;
            pot_start_q <= pot_start_d;
            dac_word_q  <= dac_word_d;
            pot_sel_q   <= pot_sel_d;
            pot_word_q  <= pot_word_d;
            status_q    <= status_d;
        end
    end

    assign busBramOut = status_q;
    assign dacStart   = dac_start_q;
    assign dacWord    = dac_word_q;
    assign potStart   = pot_start_q;
    assign potSel     = pot_sel_q;
    assign potWord    = pot_word_q;

endmodule

// File: tb/tb_epp_cmd_dispatcher.sv
// Directed bench for epp_cmd_dispatcher: frame table plus hand-built busy, overflow,
// timeout, bad-command and mid-frame reset sequences.
module tb_epp_cmd_dispatcher;

    localparam int TMO = 1000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        dataStb;
    logic [7:0]  busBramIn;
    logic [7:0]  busBramOut;
    logic        dacBusy, dacStart, potBusy, potStart;
    logic [15:0] dacWord;
    logic [1:0]  potSel;
    logic [7:0]  potWord;

    epp_cmd_dispatcher #(.TIMEOUT(TMO), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .dataStb(dataStb), .busBramIn(busBramIn),
        .busBramOut(busBramOut), .dacBusy(dacBusy), .dacStart(dacStart),
        .dacWord(dacWord), .potBusy(potBusy), .potStart(potStart),
        .potSel(potSel), .potWord(potWord)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          dac_starts = 0;
    int          pot_starts = 0;
    logic [15:0] dac_log[$];

    always @(negedge clk) begin
        if (dacStart) begin
            dac_starts <= dac_starts + 1;
            dac_log.push_back(dacWord);
        end
        if (potStart) pot_starts <= pot_starts + 1;
    end

    typedef struct {
        logic [7:0]  cmd, hi, lo;
        logic        is_dac;
        logic [1:0]  sel;
        logic [15:0] word;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe low for one clock, leaving it high on return; data stays on the bus.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        busBramIn = b;
        dataStb   = 1'b0;
        @(negedge clk);
        dataStb   = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
        send_byte(c); idle(6);
        send_byte(h); idle(6);
        send_byte(l); idle(8);
    endtask

    int d0, p0, lat;
    logic [15:0] word_at_start;

    initial begin
        vecs[0] = '{cmd: 8'h03, hi: 8'h55, lo: 8'h01, is_dac: 1'b0, sel: 2'd2, word: 16'h0001};
        vecs[1] = '{cmd: 8'h00, hi: 8'h12, lo: 8'h34, is_dac: 1'b1, sel: 2'd0, word: 16'h1234};
        vecs[2] = '{cmd: 8'h01, hi: 8'hAA, lo: 8'h7E, is_dac: 1'b0, sel: 2'd0, word: 16'h007E};
        vecs[3] = '{cmd: 8'h02, hi: 8'hFF, lo: 8'hC3, is_dac: 1'b0, sel: 2'd1, word: 16'h00C3};
        vecs[4] = '{cmd: 8'h00, hi: 8'hAB, lo: 8'hCD, is_dac: 1'b1, sel: 2'd0, word: 16'hABCD};

        rstn = 1'b0; dataStb = 1'b1; busBramIn = 8'h00; dacBusy = 1'b0; potBusy = 1'b0;
        idle(3);
        chk("reset_status", 32'(busBramOut), 32'h00);
        chk("reset_outs", {dacStart, potStart, potSel, potWord, dacWord}, 32'h0);
        rstn = 1'b1;
        idle(5);

        // Frame table: engines idle, start 5 negedges after the final strobe rises.
        for (int i = 0; i < 5; i++) begin
            d0 = dac_starts; p0 = pot_starts;
            send_byte(vecs[i].cmd); idle(6);
            send_byte(vecs[i].hi);  idle(6);
            send_byte(vecs[i].lo);
            lat = 0;
            while (lat < 20 && !(dacStart || potStart)) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
            if (vecs[i].is_dac) chk($sformatf("v%0d_dacWord", i), 32'(dacWord), 32'(vecs[i].word));
            else chk($sformatf("v%0d_pot", i), {22'd0, potSel, potWord}, {22'd0, vecs[i].sel, vecs[i].word[7:0]});
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), {dacStart, potStart}, 2'b00);
            idle(8);
            chk($sformatf("v%0d_dac_cnt", i), 32'(dac_starts - d0), 32'(vecs[i].is_dac ? 1 : 0));
            chk($sformatf("v%0d_pot_cnt", i), 32'(pot_starts - p0), 32'(vecs[i].is_dac ? 0 : 1));
            chk($sformatf("v%0d_status", i), 32'(busBramOut), 32'h00);
        end

        // DAC busy holds the head; release starts it the following cycle.
        dacBusy = 1'b1;
        d0 = dac_starts;
        send_frame(8'h00, 8'h12, 8'h34);
        idle(50);
        chk("busy_nostart", 32'(dac_starts - d0), 32'd0);
        chk("busy_status", 32'(busBramOut), 32'h04);
        dacBusy = 1'b0;
        @(negedge clk);
        chk("busy_release_start", 32'(dacStart), 32'd1);
        chk("busy_release_word", 32'(dacWord), 32'h1234);
        idle(8);
        chk("busy_count0", 32'(busBramOut), 32'h00);

        // Overflow: five frames into a 4-deep queue, sticky clear, then drain in order.
        dacBusy = 1'b1;
        dac_log.delete();
        for (int k = 1; k <= 5; k++) send_frame(8'h00, 8'(8'h11 * k), 8'(k));
        idle(4);
        chk("ovf_status", 32'(busBramOut), 32'h90);
        send_byte(8'h80); idle(8);
        chk("ovf_clear", 32'(busBramOut), 32'h10);
        dacBusy = 1'b0;
        idle(40);
        chk("ovf_drain_n", 32'(dac_log.size()), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            word_at_start = (dac_log.size() >= k) ? dac_log[k-1] : 16'hxxxx;
            chk($sformatf("ovf_order%0d", k), 32'(word_at_start), 32'({8'(8'h11 * k), 8'(k)}));
        end
        chk("ovf_drain_status", 32'(busBramOut), 32'h00);

        // Inter-byte timeout abandons the partial frame.
        send_byte(8'h03); idle(6);
        send_byte(8'h55); idle(6);
        chk("tmo_active", 32'(busBramOut), 32'h01);
        idle(TMO + 5);
        chk("tmo_status", 32'(busBramOut), 32'h40);
        p0 = pot_starts;
        send_frame(8'h01, 8'hAA, 8'h7E);
        chk("tmo_next_cnt", 32'(pot_starts - p0), 32'd1);
        chk("tmo_next_pot", {potSel, potWord}, {2'd0, 8'h7E});
        send_byte(8'h80); idle(8);

        // Bad command sets cmdErr and queues nothing.
        d0 = dac_starts; p0 = pot_starts;
        send_byte(8'h40); idle(20);
        chk("cerr_status", 32'(busBramOut), 32'h20);
        chk("cerr_nostart", 32'((dac_starts - d0) + (pot_starts - p0)), 32'd0);
        send_frame(8'h00, 8'h0F, 8'hF0);
        chk("cerr_next_word", 32'(dacWord), 32'h0FF0);
        chk("cerr_next_cnt", 32'(dac_starts - d0), 32'd1);
        send_byte(8'h80); idle(8);

        // Reset mid-frame: partial frame lost, next byte is a command.
        d0 = dac_starts; p0 = pot_starts;
        send_byte(8'h00); idle(6);
        send_byte(8'h12); idle(6);
        rstn = 1'b0;
        #1;
        chk("rst_status", 32'(busBramOut), 32'h00);
        chk("rst_outs", {dacStart, potStart, potSel, potWord, dacWord}, 32'h0);
        idle(2);
        rstn = 1'b1;
        idle(3);
        send_frame(8'h02, 8'h00, 8'h88);
        idle(10);
        chk("rst_pot_cnt", 32'(pot_starts - p0), 32'd1);
        chk("rst_pot", {potSel, potWord}, {2'd1, 8'h88});
        chk("rst_no_dac", 32'(dac_starts - d0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/epp_cmd_dispatcher.md
Name: epp_cmd_dispatcher

Overview:
Front-end sequencer between the EPP byte port (dataStb/busBramIn) and the two serial engines, the DAC SPI shifter and the shared digital-pot SPI shifter. It assembles 3-byte command frames, queues them in a small FIFO, and dispatches them in order to the addressed engine using a start/busy handshake. It also drives a status byte on busBramOut so the host can poll it.

Parameters:
TIMEOUT, 1000, inter-byte timeout in clk cycles while a frame is partially received
FIFO_DEPTH, 4, frame queue depth; power of two, at least 2

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
dataStb  in  1  EPP data strobe, active low, asynchronous to clk
busBramIn  in  8  EPP data byte, valid while dataStb is low and at its rising edge
busBramOut  out  8  status byte
dacBusy  in  1  DAC shifter busy
dacStart  out  1  one-cycle start pulse to DAC shifter
dacWord  out  16  DAC data word
potBusy  in  1  pot shifter busy
potStart  out  1  one-cycle start pulse to pot shifter
potSel  out  2  pot select: 0=dpot1, 1=dpot2, 2=dpot3
potWord  out  8  pot data byte

Behaviour:
- Reset (rstn=0, asynchronous): all outputs 0, FIFO empty, sticky bits 0, assembler in S_CMD, dispatcher in D_IDLE. A reset during a frame discards it.
- Input sync: dataStb and busBramIn each pass through 2 flops.
- Byte accept: occurs on the first cycle a low-to-high edge is seen on the synced dataStb (2–3 clk after the raw edge). The synced busBramIn is captured on that cycle.
- Host timing requirement: dataStb low for at least 1 clk and high for at least 3 clk between strobes.
- Assembler FSM, states S_CMD -> S_HI -> S_LO:
  - S_CMD, cmd byte with bits[7:2]=0: latch target=bits[1:0] (0=DAC, 1..3=dpot1..3), go to S_HI.
  - S_CMD, cmd=0x80: clear all sticky bits, stay in S_CMD.
  - S_CMD, any other cmd: set cmdErr sticky, stay in S_CMD.
  - S_HI: latch hi byte, go to S_LO.
  - S_LO: latch lo byte, push {target, hi, lo} into FIFO on the next cycle, return to S_CMD.
- FIFO full at push: the frame is dropped, ovf sticky is set, and FIFO contents are unchanged.
- Timeout: a counter clears on every byte accept and counts while in S_HI or S_LO. When it reaches TIMEOUT, set tmo sticky and return to S_CMD. A byte accept on that same cycle takes priority, so no timeout occurs.
- Dispatcher FSM, states D_IDLE -> D_START -> D_ACK -> D_WAIT, strictly in order (a head blocked on a busy engine blocks the rest of the queue):
  - D_IDLE: if FIFO is non-empty and the target engine's busy=0, pop the head and go to D_START.
  - D_START: drive word outputs and assert start for exactly 1 cycle.
    - DAC target: dacWord={hi,lo}.
    - Pot target: potSel=target-1, potWord=lo; hi byte ignored.
  - D_ACK: wait 1 cycle (engine raises busy).
  - D_WAIT: wait until target busy=0, then go to D_IDLE.
  - Word outputs hold their last value between dispatches.
- Latency: with FIFO empty and engine idle, start asserts 3 clk after the final byte accept (push, pop, start).
- Simultaneous push and pop on a full FIFO: the pop happens first, so the push succeeds.
- busBramOut = {ovf, tmo, cmdErr, count[2:0] (saturates at 7), dispatching (state != D_IDLE), frameActive (state != S_CMD)}. Registered; updates the cycle after a state change.

Test Plan:
1. Strobes with bytes 0x03, 0x55, 0x01, potBusy=0 -> single potStart pulse; potSel=2, potWord=0x01; dacStart stays 0; busBramOut returns to 0x00 once potBusy falls.
2. Frame 0x00, 0x12, 0x34 with dacBusy=1 held 50 clk -> no dacStart while busy; after dacBusy falls, dacWord=0x1234 and a dacStart pulse 1 cycle later; count goes 1 -> 0.
3. Five DAC frames with dacBusy=1 -> count=4, bit7 (ovf)=1; then cmd 0x80 -> bit7=0, count still 4; release busy -> 4 starts in order, frame 5 never issued.
4. Bytes 0x03, 0x55, then idle TIMEOUT+5 clk -> bit6 (tmo)=1, frameActive=0; next frame 0x01, 0xAA, 0x7E -> potSel=0, potWord=0x7E.
5. Cmd byte 0x40 -> bit5 (cmdErr)=1, no frame pushed; a following valid frame dispatches normally.
6. rstn pulse low after the hi byte of a frame -> all outputs 0 immediately; next lo-looking byte 0x02 is treated as a cmd (target dpot2); no stale dispatch.
